// File: rtl/led_scroll_feeder_if.sv
// Display bus between the scroll feeder and the seven-segment stage.
// The master side drives the character, anodes and status outputs and
// samples the debounced button level. The slave side is the consumer
// view: the decoder, the anode pins and whatever supplies the button.
interface led_scroll_feeder_if;
    logic       button;
    logic [3:0] char;
    logic       an3;
    logic       an2;
    logic       an1;
    logic       an0;
    logic [3:0] offset;
    logic       frame_tick;

    modport master (
        input  button,
        output char,
        output an3,
        output an2,
        output an1,
        output an0,
        output offset,
        output frame_tick
    );

    modport slave (
        output button,
        input  char,
        input  an3,
        input  an2,
        input  an1,
        input  an0,
        input  offset,
        input  frame_tick
    );
endinterface

// File: rtl/led_scroll_feeder.sv
// Four-digit scrolling message source for the seven-segment driver.
// Digits 3 down to 0 each get one slot of DIGIT_CYCLES clocks. The first
// DEAD_CYCLES clocks of every slot keep all anodes dark so the previous
// digit's segments never bleed into the next one. A rising button edge
// is remembered and applied only on the last cycle of the digit 0 slot,
// so the window always moves between frames and never in the middle of one.
module led_scroll_feeder #(
    parameter logic [63:0] MESSAGE      = 64'h0123456789ABCDEF,
    parameter logic [15:0] DIGIT_CYCLES = 16'd4096,
    parameter logic [15:0] DEAD_CYCLES  = 16'd256
) (
    input  logic                 clk,
    input  logic                 reset,
    led_scroll_feeder_if.master  bus
);

    typedef enum logic [1:0] {
        DIGIT0 = 2'd0,
        DIGIT1 = 2'd1,
        DIGIT2 = 2'd2,
        DIGIT3 = 2'd3
    } digit_t;

    localparam logic [15:0] SLOT_LAST = DIGIT_CYCLES - 16'd1;

    digit_t      digit;
    digit_t      digit_next;
    logic [15:0] slot_cnt;
    logic [15:0] slot_cnt_next;
    logic [3:0]  offset;
    logic [3:0]  offset_next;
    logic        pending;
    logic        pending_next;
    logic        btn_q;

    logic        slot_last;
    logic        frame_end;
    logic        rise;
    logic [3:0]  char_idx;
    logic [3:0]  anodes;

    // Register the display position, the window offset and the button history.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit    <= DIGIT3;
            slot_cnt <= 16'd0;
            offset   <= 4'd0;
            pending  <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            digit    <= digit_next;
            slot_cnt <= slot_cnt_next;
            offset   <= offset_next;
            pending  <= pending_next;
            btn_q    <= bus.button;
        end
    end

    // Slot counter and digit sequencer: 3, 2, 1, 0, then back to 3.
    always_comb begin
        slot_last     = (slot_cnt == SLOT_LAST);
        frame_end     = slot_last && (digit == DIGIT0);
        slot_cnt_next = slot_cnt + 16'd1;
        digit_next    = digit;
        if (slot_last) begin
            slot_cnt_next = 16'd0;
            case (digit)
                DIGIT3:  digit_next = DIGIT2;
                DIGIT2:  digit_next = DIGIT1;
                DIGIT1:  digit_next = DIGIT0;
                default: digit_next = DIGIT3;
            endcase
        end
    end

    // Latch one button press and move the window only at the frame boundary.
    always_comb begin
        rise         = bus.button & ~btn_q;
        offset_next  = offset;
        pending_next = pending;
        if (frame_end && (pending || rise)) begin
            offset_next  = offset + 4'd1;
            pending_next = 1'b0;
        end else if (rise) begin
            pending_next = 1'b1;
        end
    end

    // Pick the message nibble for the active digit and light its anode after the dead-time.
    always_comb begin
        char_idx = offset + {2'b00, ~digit};
        anodes   = 4'b1111;
        if (slot_cnt >= DEAD_CYCLES) begin
            case (digit)
                DIGIT3:  anodes = 4'b0111;
                DIGIT2:  anodes = 4'b1011;
                DIGIT1:  anodes = 4'b1101;
                default: anodes = 4'b1110;
            endcase
        end
    end

    assign bus.char       = MESSAGE[{~char_idx, 2'b00} +: 4];
    assign bus.an3        = anodes[3];
    assign bus.an2        = anodes[2];
    assign bus.an1        = anodes[1];
    assign bus.an0        = anodes[0];
    assign bus.offset     = offset;
    assign bus.frame_tick = frame_end;

endmodule

// File: tb/tb_led_scroll_feeder.sv
// Directed bench for led_scroll_feeder with short slots (8 cycles, 2 dark).
// The default message has nibble value equal to its index, so the expected
// character for a digit is simply the window offset plus its position.
module tb_led_scroll_feeder;

    localparam int D = 8;
    localparam int B = 2;
    localparam int F = 4 * D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    led_scroll_feeder_if bus ();

    led_scroll_feeder #(
        .MESSAGE      (64'h0123456789ABCDEF),
        .DIGIT_CYCLES (16'd8),
        .DEAD_CYCLES  (16'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for n checked cycles; returns at the start of cycle 0.
    task automatic applyReset(input int n);
        reset = 1'b1;
        bus.button = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("rst.an.%0d", i), {12'd0, bus.an3, bus.an2, bus.an1, bus.an0}, 16'h000F);
            checkOutput($sformatf("rst.char.%0d", i), {12'd0, bus.char}, 16'h0000);
            checkOutput($sformatf("rst.off.%0d", i), {12'd0, bus.offset}, 16'h0000);
            checkOutput($sformatf("rst.tick.%0d", i), {15'd0, bus.frame_tick}, 16'h0000);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Run frame cycles 0..lastCycle with button = pattern[cycle], checking every cycle.
    task automatic applyStimulus(input string tag, input logic [3:0] expOff,
                                 input logic [31:0] pattern, input int lastCycle);
        int         dig;
        int         slot;
        logic [3:0] expAn;
        logic [3:0] expChar;
        logic [3:0] an;
        for (int c = 0; c <= lastCycle; c++) begin
            bus.button = pattern[c];
            #2;
            dig     = 3 - (c / D);
            slot    = c % D;
            expAn   = 4'b1111;
            if (slot >= B) expAn[dig] = 1'b0;
            expChar = expOff + 4'(3 - dig);
            an      = {bus.an3, bus.an2, bus.an1, bus.an0};
            checkOutput($sformatf("%s.an.c%0d", tag, c), {12'd0, an}, {12'd0, expAn});
            checkOutput($sformatf("%s.char.c%0d", tag, c), {12'd0, bus.char}, {12'd0, expChar});
            checkOutput($sformatf("%s.off.c%0d", tag, c), {12'd0, bus.offset}, {12'd0, expOff});
            checkOutput($sformatf("%s.tick.c%0d", tag, c), {15'd0, bus.frame_tick},
                        (c == F - 1) ? 16'd1 : 16'd0);
            checkOutput($sformatf("%s.onehot.c%0d", tag, c), 16'($countones(~an) <= 1), 16'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.button = 1'b0;

        // Reset, then first frame with a single press at cycle 12.
        applyReset(3);
        applyStimulus("f1press", 4'd0, 32'h0000_1000, F - 1);
        applyStimulus("f2", 4'd1, 32'h0, F - 1);

        // One press per frame until the offset wraps back to 0.
        for (int k = 1; k <= 15; k++) begin
            applyStimulus($sformatf("wrap%0d", k), 4'(k), 32'h0000_0008, F - 1);
        end
        applyStimulus("wrap0", 4'd0, 32'h0, F - 1);

        // Three edges within one frame collapse to one advance.
        applyStimulus("multi", 4'd0, 32'h0010_0408, F - 1);
        applyStimulus("multiAfter", 4'd1, 32'h0, F - 1);

        // Button held high across three frames advances once.
        applyStimulus("hold1", 4'd1, 32'hFFFF_FFFF, F - 1);
        applyStimulus("hold2", 4'd2, 32'hFFFF_FFFF, F - 1);
        applyStimulus("hold3", 4'd2, 32'hFFFF_FFFF, F - 1);
        applyStimulus("holdRel", 4'd2, 32'h0, F - 1);
        applyStimulus("holdAfter", 4'd2, 32'h0, F - 1);

        // Edge landing exactly on the frame boundary cycle.
        applyReset(2);
        applyStimulus("bound", 4'd0, 32'h8000_0000, F - 1);
        applyStimulus("boundAfter", 4'd1, 32'h0, F - 1);

        // Press at cycle 5, reset at cycle 20: the pending press is lost.
        applyReset(2);
        applyStimulus("midRst", 4'd0, 32'h0000_0020, 19);
        applyReset(2);
        applyStimulus("postRst1", 4'd0, 32'h0, F - 1);
        applyStimulus("postRst2", 4'd0, 32'h0, F - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scroll_feeder.md
# led_scroll_feeder

Display-data source for the four-digit seven-segment driver. It sits directly upstream of the hex-to-segment decoder and the anode pins. It time-multiplexes a 4-character window of a 16-nibble message onto the shared `char` bus and drives the active-low anode enables, inserting a blanking dead-time before each digit to prevent ghosting. Each rising edge of the debounced button advances the window by one character; the advance is applied only at frame boundaries so a frame is never torn.

## Interface
- `MESSAGE`, default 64'h0123456789ABCDEF: message nibbles. Index 0 = bits [63:60], index 15 = bits [3:0].
- `DIGIT_CYCLES`, default 16'd4096: clk cycles per digit slot. Legal range 2..65535.
- `DEAD_CYCLES`, default 16'd256: blanking cycles at the start of each slot. Legal range 1..DIGIT_CYCLES-1.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high. The stabilized reset feeds this port.
- `button` input 1: debounced button level, synchronous to `clk`.
- `char` output 4: nibble for the decoder.
- `an3`, `an2`, `an1`, `an0` output 1 each: anode enables, active-low. `an3` is the leftmost digit.
- `offset` output 4: current window start index.
- `frame_tick` output 1: one-cycle pulse on the last cycle of each frame.

## Operation
- **State:**
  - `digit` (3→2→1→0→3).
  - 16-bit `slot_cnt` (0..DIGIT_CYCLES-1).
  - 4-bit `offset`.
  - `pending` flag.
  - `btn_q`, which holds the previous `button` value for edge detection.
- **Slot sequence:** `slot_cnt` increments every cycle. When it equals DIGIT_CYCLES-1 it wraps to 0 and `digit` steps down; after digit 0 it returns to digit 3.
- **Anodes:**
  - All anodes are 1 while `slot_cnt` < DEAD_CYCLES.
  - While `slot_cnt` >= DEAD_CYCLES, only the selected digit's anode is 0.
  - At most one anode is 0 in any cycle.
- **Character mapping:** the digit n slot shows message index (`offset` + (3−n)) mod 16. The 4-bit add wraps naturally.
  - `an3` shows index `offset`.
  - `an0` shows index `offset`+3.
- **`char` timing:** `char` holds the selected digit's nibble for the whole slot, including the dead-time. It changes only on slot cycle 0.
- **Button:**
  - A rising edge is detected when `button` is 1 and `btn_q` is 0. The edge sets `pending`.
  - Further edges while `pending` is already set are dropped; there is no queueing.
- **Offset update:** happens on the last cycle of the digit 0 slot (the frame boundary). If `pending` is set, or a rising edge occurs in that same cycle:
  - `offset` increments by 1 (15→0),
  - `pending` clears,
  - the next frame's digit 3 slot uses the new offset.
- **`frame_tick`:** 1 exactly on the frame boundary cycle, otherwise 0.
- **Reset values:**
  - `digit`=3, `slot_cnt`=0, `offset`=0, `pending`=0, `btn_q`=0.
  - Anodes all 1, `frame_tick`=0.
  - `char`=MESSAGE[63:60].
- **Reset mid-frame:** immediately aborts the slot and clears `pending`. Display restarts at the digit 3 dead-time.

## Timing
- Cycle 0 is the first cycle with `reset`=0. With D=DIGIT_CYCLES and B=DEAD_CYCLES:
  - `an3`=0 on cycles B..D−1.
  - `an2`=0 on cycles D+B..2D−1.
  - `an1`=0 on cycles 2D+B..3D−1.
  - `an0`=0 on cycles 3D+B..4D−1.
  - Frame period is 4D.
- `frame_tick`=1 on cycles 4D−1, 8D−1, and so on.
- `char` for digit n is valid from the first cycle of its slot. This gives B cycles of setup before the anode turns on.
- Button edge to visible change: the edge at cycle t updates `offset` at the end of the first frame boundary cycle ≥ t. The new `char` appears on the following cycle.
- If `button` is held high, it advances the window only once.
- An edge arriving in the same cycle as `reset`=1 is discarded.

## Test plan
1. **Reset and first frame.** DIGIT_CYCLES=8, DEAD_CYCLES=2, default MESSAGE. Assert `reset` for 3 cycles, then run one frame.
   - During reset: anodes 1111, `char`=0, `offset`=0.
   - After release: `an3` low on cycles 2–7 with `char`=0, `an2` low 10–15 with `char`=1, `an1` low 18–23 with `char`=2, `an0` low 26–31 with `char`=3.
   - `frame_tick` high only at cycle 31.
2. **Single press.** Pulse `button` high at cycle 12.
   - `offset` becomes 1 after cycle 31.
   - Frame 2 shows 1, 2, 3, 4.
   - Frame 1 is unchanged.
3. **Wrap.** Deliver 14 presses, one per frame.
   - With `offset`=14, digits show E, F, 0, 1.
   - One more press gives `offset`=15 and digits F, 0, 1, 2. Another gives `offset`=0.
4. **Press collapsing.** Three rising edges within one frame, and separately `button` held high for 3 frames.
   - Each case advances `offset` by exactly 1.
5. **Boundary-coincident edge.** Rising edge exactly at cycle 31.
   - `offset`=1 from cycle 32.
   - The digit 3 slot shows `char`=1.
6. **Mid-frame reset with pending.** Press at cycle 5, then assert `reset` at cycle 20.
   - `offset` stays 0, anodes go to 1111, `pending` is lost.
   - After release, the first frame shows 0, 1, 2, 3.
   - Throughout all tests, no cycle has more than one anode at 0.
